// File: rtl/fnd_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : fnd_scan_driver
//  Purpose  : Multiplexed 8-digit seven-segment (FND) scan driver. Follows an
//             external scan position, inserts inter-digit dead time on every
//             position change, decodes BCD to active-low segments, drives the
//             active-low digit commons, emits a per-frame pulse and applies
//             a frame-counted blink to masked digits.
//  Ports    : i_clk        - system clock, rising edge
//             i_rst_n      - asynchronous active-low reset
//             i_pos[2:0]   - scan position (7 down to 0, wraps to 7)
//             i_digits[31:0] - BCD digit k at [4k+3:4k]
//             i_dp[7:0]    - decimal point request per digit (1 = lit)
//             i_blink_mask[7:0] - 1 = digit k blinks
//             o_seg[6:0]   - active-low segments, bit0=a .. bit6=g
//             o_dp         - active-low decimal point
//             o_com[7:0]   - active-low one-hot digit common
//             o_frame      - one-cycle pulse per completed scan frame
//  Revision : 1.0 - initial release
// ============================================================================
module fnd_scan_driver #(
  parameter int BLANK_CYC    = 4,   // dead-time cycles, 0..255
  parameter int BLINK_FRAMES = 125  // frames per blink toggle, 1..65535
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_pos,
  input  logic [31:0] i_digits,
  input  logic [7:0]  i_dp,
  input  logic [7:0]  i_blink_mask,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [7:0]  o_com,
  output logic        o_frame
);

  localparam logic [7:0]  c_BLANK      = 8'(BLANK_CYC);
  localparam logic [15:0] c_FRAME_LAST = 16'(BLINK_FRAMES - 1);
  localparam logic [6:0]  c_SEG_OFF    = 7'h7F;
  localparam logic [7:0]  c_COM_OFF    = 8'hFF;

  logic [2:0]  r_pos_q;
  logic [7:0]  r_blank_cnt;
  logic [15:0] r_frame_cnt;
  logic        r_blink_phase;
  logic [6:0]  r_seg;
  logic        r_dp;
  logic [7:0]  r_com;
  logic        r_frame;

  logic        w_change;
  logic        w_frame_evt;
  logic [3:0]  w_code;
  logic [6:0]  w_seg_dec;
  logic        w_blink_off;

  assign w_change    = (i_pos != r_pos_q);
  // A frame completes when the shifter wraps from position 0 back to 7.
  assign w_frame_evt = (r_pos_q == 3'd0) && (i_pos == 3'd7);
  assign w_code      = i_digits[{r_pos_q, 2'b00} +: 4];
  assign w_blink_off = i_blink_mask[r_pos_q] && r_blink_phase;

  // BCD to active-low gfedcba; non-decimal codes blank the segments.
  always_comb begin
    w_seg_dec = c_SEG_OFF;
    case (w_code)
      4'd0:    w_seg_dec = 7'h40;
      4'd1:    w_seg_dec = 7'h79;
      4'd2:    w_seg_dec = 7'h24;
      4'd3:    w_seg_dec = 7'h30;
      4'd4:    w_seg_dec = 7'h19;
      4'd5:    w_seg_dec = 7'h12;
      4'd6:    w_seg_dec = 7'h02;
      4'd7:    w_seg_dec = 7'h78;
      4'd8:    w_seg_dec = 7'h00;
      4'd9:    w_seg_dec = 7'h10;
      default: w_seg_dec = c_SEG_OFF;
    endcase
  end

  // Scan / dead-time control and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos_q     <= 3'b111;
      r_blank_cnt <= c_BLANK;
      r_com       <= c_COM_OFF;
      r_seg       <= c_SEG_OFF;
      r_dp        <= 1'b1;
    end else begin
      r_pos_q <= i_pos;
      if (w_change) begin
        // Any movement, even mid dead-time, restarts the blanking window.
        r_blank_cnt <= c_BLANK;
        r_com       <= c_COM_OFF;
        r_seg       <= c_SEG_OFF;
        r_dp        <= 1'b1;
      end else if (r_blank_cnt != 8'd0) begin
        r_blank_cnt <= r_blank_cnt - 8'd1;
        r_com       <= c_COM_OFF;
        r_seg       <= c_SEG_OFF;
        r_dp        <= 1'b1;
      end else begin
        r_com <= ~(8'b1 << r_pos_q);
        // Blinking digits keep their common driven so the scan duty is even.
        if (w_blink_off) begin
          r_seg <= c_SEG_OFF;
          r_dp  <= 1'b1;
        end else begin
          r_seg <= w_seg_dec;
          r_dp  <= ~i_dp[r_pos_q];
        end
      end
    end
  end

  // Frame pulse, frame counter and blink phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame       <= 1'b0;
      r_frame_cnt   <= 16'd0;
      r_blink_phase <= 1'b0;
    end else begin
      r_frame <= w_frame_evt;
      if (w_frame_evt) begin
        if (r_frame_cnt >= c_FRAME_LAST) begin
          r_frame_cnt   <= 16'd0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
      end
    end
  end

  assign o_seg   = r_seg;
  assign o_dp    = r_dp;
  assign o_com   = r_com;
  assign o_frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fnd_scan_driver
//  Purpose  : Directed self-checking bench for fnd_scan_driver with
//             BLANK_CYC=4 and BLINK_FRAMES=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fnd_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  pos = 3'd7;
  logic [31:0] digits = 32'h0;
  logic [7:0]  dp = 8'h0;
  logic [7:0]  mask = 8'h0;
  logic [6:0]  seg;
  logic        odp;
  logic [7:0]  com;
  logic        frame;

  int n_pass  = 0;
  int n_total = 0;

  fnd_scan_driver #(.BLANK_CYC(4), .BLINK_FRAMES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pos(pos), .i_digits(digits),
    .i_dp(dp), .i_blink_mask(mask), .o_seg(seg), .o_dp(odp),
    .o_com(com), .o_frame(frame)
  );

  always #5 clk = ~clk;

  // Hand-written segment table (active-low gfedcba).
  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40; 4'd1: return 7'h79; 4'd2: return 7'h24;
      4'd3: return 7'h30; 4'd4: return 7'h19; 4'd5: return 7'h12;
      4'd6: return 7'h02; 4'd7: return 7'h78; 4'd8: return 7'h00;
      4'd9: return 7'h10; default: return 7'h7F;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold a position for n edges, counting o_frame pulses seen.
  task automatic hold_pos(input logic [2:0] p, input int n, output int pulses);
    pulses = 0;
    pos = p;
    for (int i = 0; i < n; i++) begin
      step();
      if (frame === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    pos = 3'd7;
    digits = 32'h5100_0000;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({com, seg, odp} !== {8'hFF, 7'h7F, 1'b1})
      $display("FAIL reset_async: got com=%h seg=%h dp=%b want FF 7F 1", com, seg, odp);
    else n_pass++;
    for (int i = 0; i < 3; i++) step();
    n_total++;
    if ({com, seg, odp, frame} !== {8'hFF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL reset_held: got com=%h seg=%h dp=%b frame=%b want FF 7F 1 0", com, seg, odp, frame);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_power_up();
    for (int e = 1; e <= 4; e++) begin
      step();
      n_total++;
      if ({com, seg, odp} !== {8'hFF, 7'h7F, 1'b1})
        $display("FAIL powerup_off edge %0d: got com=%h seg=%h dp=%b want FF 7F 1", e, com, seg, odp);
      else n_pass++;
    end
    step();
    n_total++;
    if ({com, seg, odp} !== {8'h7F, 7'h12, 1'b1})
      $display("FAIL powerup_digit7: got com=%h seg=%h dp=%b want 7F 12 1", com, seg, odp);
    else n_pass++;
  endtask

  task automatic test_pos_change();
    dp = 8'h40;
    pos = 3'd6;
    for (int e = 0; e < 5; e++) begin
      step();
      n_total++;
      if ({com, seg, odp} !== {8'hFF, 7'h7F, 1'b1})
        $display("FAIL change_off N+%0d: got com=%h seg=%h dp=%b want FF 7F 1", e, com, seg, odp);
      else n_pass++;
    end
    step();
    n_total++;
    if ({com, seg, odp} !== {8'hBF, 7'h79, 1'b0})
      $display("FAIL change_digit6: got com=%h seg=%h dp=%b want BF 79 0", com, seg, odp);
    else n_pass++;
  endtask

  task automatic test_decode();
    int pc;
    digits[15:12] = 4'hB;
    hold_pos(3'd3, 6, pc);
    n_total++;
    if ({com, seg, odp} !== {8'hF7, 7'h7F, 1'b1})
      $display("FAIL blank_code_B: got com=%h seg=%h dp=%b want F7 7F 1", com, seg, odp);
    else n_pass++;
    // Digits are sampled live: each new code shows on the following edge.
    for (int c = 0; c < 16; c++) begin
      digits[15:12] = 4'(c);
      step();
      n_total++;
      if ({com, seg} !== {8'hF7, exp_seg(4'(c))})
        $display("FAIL decode_%0d: got com=%h seg=%h want F7 %h", c, com, seg, exp_seg(4'(c)));
      else n_pass++;
    end
  endtask

  task automatic test_restart();
    digits[7:4] = 4'd9;
    pos = 3'd2;
    for (int e = 0; e < 3; e++) step();
    pos = 3'd1;
    for (int e = 0; e < 5; e++) begin
      step();
      n_total++;
      if ({com, seg, odp} !== {8'hFF, 7'h7F, 1'b1})
        $display("FAIL restart_off M+%0d: got com=%h seg=%h dp=%b want FF 7F 1", e, com, seg, odp);
      else n_pass++;
    end
    step();
    n_total++;
    if ({com, seg, odp} !== {8'hFD, 7'h10, 1'b1})
      $display("FAIL restart_digit1: got com=%h seg=%h dp=%b want FD 10 1", com, seg, odp);
    else n_pass++;
    for (int e = 0; e < 8; e++) begin
      pos = (e % 2 == 0) ? 3'd4 : 3'd5;
      step();
      n_total++;
      if ({com, seg, odp} !== {8'hFF, 7'h7F, 1'b1})
        $display("FAIL toggle_off %0d: got com=%h seg=%h dp=%b want FF 7F 1", e, com, seg, odp);
      else n_pass++;
    end
  endtask

  // One full sweep 6..0 checking digit 6 and that no frame pulse occurs.
  task automatic sweep_down(input string tag);
    int pc;
    int tot;
    hold_pos(3'd6, 6, pc);
    tot = pc;
    n_total++;
    if ({com, seg} !== {8'hBF, 7'h78})
      $display("FAIL %s_digit6: got com=%h seg=%h want BF 78", tag, com, seg);
    else n_pass++;
    for (int p = 5; p >= 0; p--) begin
      hold_pos(3'(p), 6, pc);
      tot += pc;
    end
    n_total++;
    if (tot !== 0)
      $display("FAIL %s_no_pulse: got %0d pulses want 0", tag, tot);
    else n_pass++;
  endtask

  task automatic test_frame_blink();
    int pc;
    logic [6:0] want;
    digits = 32'h8765_4321;
    dp = 8'h00;
    mask = 8'h80;
    hold_pos(3'd0, 6, pc);
    n_total++;
    if (pc !== 0) $display("FAIL pre_frame_pulse: got %0d want 0", pc);
    else n_pass++;
    for (int f = 1; f <= 3; f++) begin
      hold_pos(3'd7, 6, pc);
      n_total++;
      if (pc !== 1) $display("FAIL frame%0d_pulses: got %0d want 1", f, pc);
      else n_pass++;
      // Phase is 1 after the 2nd and 3rd pulse only.
      want = (f == 2 || f == 3) ? 7'h7F : 7'h00;
      n_total++;
      if ({com, seg, odp} !== {8'h7F, want, 1'b1})
        $display("FAIL frame%0d_digit7: got com=%h seg=%h dp=%b want 7F %h 1", f, com, seg, odp, want);
      else n_pass++;
      sweep_down($sformatf("frame%0d", f));
    end
  endtask

  task automatic test_reset_mid();
    int pc;
    // Currently showing digit 0 with blink phase 1 and one frame counted.
    n_total++;
    if (com !== 8'hFE) $display("FAIL pre_reset_display: got com=%h want FE", com);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({com, seg, odp, frame} !== {8'hFF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL midreset_async: got com=%h seg=%h dp=%b frame=%b want FF 7F 1 0", com, seg, odp, frame);
    else n_pass++;
    pos = 3'd7;
    step();
    rst_n = 1'b1;
    hold_pos(3'd7, 6, pc);
    n_total++;
    if (pc !== 0) $display("FAIL midreset_pulse: got %0d want 0", pc);
    else n_pass++;
    n_total++;
    if ({com, seg} !== {8'h7F, 7'h00})
      $display("FAIL midreset_phase0: got com=%h seg=%h want 7F 00", com, seg);
    else n_pass++;
    // With frame_cnt cleared, one more frame must not toggle the phase.
    sweep_down("postreset");
    hold_pos(3'd7, 6, pc);
    n_total++;
    if ({pc, com, seg} !== {32'd1, 8'h7F, 7'h00})
      $display("FAIL postreset_frame1: got pulses=%0d com=%h seg=%h want 1 7F 00", pc, com, seg);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_pos_change();
    test_decode();
    test_restart();
    test_frame_blink();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
